// File: rtl/scan_code_buffer.sv
// PS/2 scan-code history buffer: decodes make/break/extended sequences,
// suppresses typematic repeats and keeps the four most recent key presses.
module scan_code_buffer #(
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0] CLEAR_CODE     = 8'h76
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  code_in,
  input  logic        code_valid,
  output logic [31:0] scan_codes,
  output logic        new_key,
  output logic        key_held
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GOT_F0, GOT_E0, GOT_E0F0} state_t;

  state_t           state;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_expired;

  // Expiry fires on the cycle the counter would reach TIMEOUT_CYCLES.
  assign tmo_expired = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      held_code  <= 8'h00;
      tmo_cnt    <= '0;
      scan_codes <= 32'h0;
      new_key    <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      new_key <= 1'b0;
      if (code_valid) begin
        // A valid byte always wins over a simultaneous timeout expiry.
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (code_in == 8'hF0) begin
              state <= GOT_F0;
            end else if (code_in == 8'hE0) begin
              state <= GOT_E0;
            end else if (code_in == 8'hAA || code_in == 8'h00) begin
              state <= IDLE;
            end else if (code_in == CLEAR_CODE) begin
              scan_codes <= 32'h0;
              key_held   <= 1'b0;
            end else if (key_held && code_in == held_code) begin
              state <= IDLE;
            end else begin
              scan_codes <= {scan_codes[23:0], code_in};
              held_code  <= code_in;
              key_held   <= 1'b1;
              new_key    <= 1'b1;
            end
          end
          GOT_F0: begin
            if (key_held && code_in == held_code) key_held <= 1'b0;
            state <= IDLE;
          end
          GOT_E0: begin
            state <= (code_in == 8'hF0) ? GOT_E0F0 : IDLE;
          end
          GOT_E0F0: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_expired) begin
        // Abandoned prefix: history and held key are left untouched.
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scan_code_buffer.sv
// Directed bench for scan_code_buffer: vector table plus hand-written
// sequences for clear, timeout boundary and asynchronous reset.
module tb_scan_code_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  code_in = 8'h00;
  logic        code_valid = 1'b0;
  logic [31:0] scan_codes;
  logic        new_key;
  logic        key_held;

  int checks = 0;
  int failures = 0;

  scan_code_buffer #(
    .TIMEOUT_CYCLES(8),
    .CLEAR_CODE    (8'h76)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .code_in   (code_in),
    .code_valid(code_valid),
    .scan_codes(scan_codes),
    .new_key   (new_key),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  code;
    logic [31:0] exp_sc;
    logic        exp_nk;
    logic        exp_kh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input logic [7:0] code,
                     input logic [31:0] sc, input logic nk, input logic kh);
    vec_t v;
    v.vld = vld; v.code = code; v.exp_sc = sc; v.exp_nk = nk; v.exp_kh = kh;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] sc, input logic nk, input logic kh);
    chk({tag, " scan_codes"}, scan_codes, sc);
    chk({tag, " new_key"}, {31'b0, new_key}, {31'b0, nk});
    chk({tag, " key_held"}, {31'b0, key_held}, {31'b0, kh});
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic vld, input logic [7:0] code);
    @(negedge clk);
    code_valid = vld;
    code_in    = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic make/break
    add(1, 8'h16, 32'h0000_0016, 1, 1);
    add(1, 8'hF0, 32'h0000_0016, 0, 1);
    add(1, 8'h16, 32'h0000_0016, 0, 0);
    add(1, 8'h1E, 32'h0000_161E, 1, 1);
    add(1, 8'hF0, 32'h0000_161E, 0, 1);
    add(1, 8'h1E, 32'h0000_161E, 0, 0);
    add(1, 8'h76, 32'h0000_0000, 0, 0);
    // Typematic repeat
    add(1, 8'h16, 32'h0000_0016, 1, 1);
    add(1, 8'h16, 32'h0000_0016, 0, 1);
    add(1, 8'h16, 32'h0000_0016, 0, 1);
    add(1, 8'hF0, 32'h0000_0016, 0, 1);
    add(1, 8'h16, 32'h0000_0016, 0, 0);
    add(1, 8'h16, 32'h0000_1616, 1, 1);
    add(0, 8'h16, 32'h0000_1616, 0, 1);
    add(1, 8'h76, 32'h0000_0000, 0, 0);
    // Wrap-around
    add(1, 8'h45, 32'h0000_0045, 1, 1);
    add(1, 8'hF0, 32'h0000_0045, 0, 1);
    add(1, 8'h45, 32'h0000_0045, 0, 0);
    add(1, 8'h16, 32'h0000_4516, 1, 1);
    add(1, 8'hF0, 32'h0000_4516, 0, 1);
    add(1, 8'h16, 32'h0000_4516, 0, 0);
    add(1, 8'h1E, 32'h0045_161E, 1, 1);
    add(1, 8'hF0, 32'h0045_161E, 0, 1);
    add(1, 8'h1E, 32'h0045_161E, 0, 0);
    add(1, 8'h26, 32'h4516_1E26, 1, 1);
    add(1, 8'hF0, 32'h4516_1E26, 0, 1);
    add(1, 8'h26, 32'h4516_1E26, 0, 0);
    add(1, 8'h25, 32'h161E_2625, 1, 1);
    add(1, 8'hF0, 32'h161E_2625, 0, 1);
    add(1, 8'h25, 32'h161E_2625, 0, 0);
    add(1, 8'h76, 32'h0000_0000, 0, 0);
    // Extended codes and noise
    add(1, 8'hE0, 32'h0000_0000, 0, 0);
    add(1, 8'h75, 32'h0000_0000, 0, 0);
    add(1, 8'hE0, 32'h0000_0000, 0, 0);
    add(1, 8'hF0, 32'h0000_0000, 0, 0);
    add(1, 8'h75, 32'h0000_0000, 0, 0);
    add(1, 8'hAA, 32'h0000_0000, 0, 0);
    add(1, 8'h00, 32'h0000_0000, 0, 0);
    add(1, 8'h3D, 32'h0000_003D, 1, 1);
    // held_code is 3D: repeat ignored, foreign break ignored, own break releases
    add(1, 8'h3D, 32'h0000_003D, 0, 1);
    add(1, 8'hF0, 32'h0000_003D, 0, 1);
    add(1, 8'h1C, 32'h0000_003D, 0, 1);
    add(1, 8'h3D, 32'h0000_003D, 0, 1);
    add(1, 8'hE0, 32'h0000_003D, 0, 1);
    add(1, 8'h3D, 32'h0000_003D, 0, 1);
    add(1, 8'hF0, 32'h0000_003D, 0, 1);
    add(1, 8'h3D, 32'h0000_003D, 0, 0);
    add(0, 8'h00, 32'h0000_003D, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk3("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 8'h00);
    chk3("post_reset", 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vld, vecs[i].code);
      chk3($sformatf("vec%0d", i), vecs[i].exp_sc, vecs[i].exp_nk, vecs[i].exp_kh);
    end

    // Timeout: eight idle cycles after F0 abandon the prefix
    step(1, 8'h76);
    chk3("clear", 32'h0, 1'b0, 1'b0);
    step(1, 8'hF0);
    for (int i = 0; i < 8; i++) step(0, 8'h00);
    step(1, 8'h2E);
    chk3("tmo_after", 32'h0000_002E, 1'b1, 1'b1);

    // Byte arriving in the expiry cycle is still a break code
    step(1, 8'h76);
    step(1, 8'hF0);
    for (int i = 0; i < 7; i++) step(0, 8'h00);
    step(1, 8'h2E);
    chk3("tmo_edge", 32'h0, 1'b0, 1'b0);
    step(1, 8'h2E);
    chk3("tmo_edge_next", 32'h0000_002E, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle after F0
    step(1, 8'hF0);
    #1;
    reset_n = 1'b0;
    #1;
    chk3("async_reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    code_valid = 1'b0;
    reset_n    = 1'b1;
    step(1, 8'h26);
    chk3("after_async", 32'h0000_0026, 1'b1, 1'b1);

    // Back-to-back makes pulse new_key on consecutive cycles
    step(1, 8'h1C);
    chk3("b2b_1", 32'h0000_261C, 1'b1, 1'b1);
    step(1, 8'h1B);
    chk3("b2b_2", 32'h0026_1C1B, 1'b1, 1'b1);
    step(0, 8'h00);
    chk3("b2b_idle", 32'h0026_1C1B, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
